// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: drives one shared external full adder LSB first.
// Optional subtract mode is enabled with the SERIAL_ADD_SUB_EN macro.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub_i,
`endif
    output logic             fa_a_o,
    output logic             fa_b_o,
    output logic             fa_cin_o,
    input  logic             fa_s_i,
    input  logic             fa_cout_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    // state   | meaning
    // IDLE    | waiting for start, full-adder inputs forced low
    // RUN     | one operand bit consumed per cycle, LSB first
    // DONE    | one-cycle result strobe, then back to IDLE
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [WIDTH-1:0] b_load;
    logic             carry_load;

`ifdef SERIAL_ADD_SUB_EN
    // a - b is formed as a + ~b + 1; carry out then means "no borrow".
    assign b_load     = sub_i ? ~b_i : b_i;
    assign carry_load = sub_i ? 1'b1 : cin_i;
`else
    assign b_load     = b_i;
    assign carry_load = cin_i;
`endif

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    sa_d    = a_i;
                    sb_d    = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d   = {fa_s_i, sum_q[WIDTH-1:1]};
                carry_d = fa_cout_i;
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cout_d  = fa_cout_i;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    logic in_run;
    assign in_run = (state_q == ST_RUN);

    assign fa_a_o   = in_run & sa_q[0];
    assign fa_b_o   = in_run & sb_q[0];
    assign fa_cin_o = in_run & carry_q;
    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = (state_q == ST_DONE);
    assign sum_o    = sum_q;
    assign cout_o   = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed-vector bench for serial_add_ctrl with a behavioural full adder attached.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cin_i;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub_i;
`endif
    logic             fa_a_o, fa_b_o, fa_cin_o;
    logic             fa_s_i, fa_cout_i;
    logic             busy_o, done_o;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk_i = ~clk_i;

    // Stand-in for the external combinational full adder.
    assign fa_s_i    = fa_a_o ^ fa_b_o ^ fa_cin_o;
    assign fa_cout_i = (fa_a_o & fa_b_o) | (fa_a_o & fa_cin_o) | (fa_b_o & fa_cin_o);

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .cin_i     (cin_i),
`ifdef SERIAL_ADD_SUB_EN
        .sub_i     (sub_i),
`endif
        .fa_a_o    (fa_a_o),
        .fa_b_o    (fa_b_o),
        .fa_cin_o  (fa_cin_o),
        .fa_s_i    (fa_s_i),
        .fa_cout_i (fa_cout_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .sum_o     (sum_o),
        .cout_o    (cout_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Pulses start for one cycle and waits (bounded) for done; returns at the done cycle.
    task automatic do_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, output logic [WIDTH-1:0] rs, output logic rc,
                          output int edges, output int busy_n);
        a_i = a; b_i = b; cin_i = c; start_i = 1'b1;
        step();
        start_i = 1'b0;
        edges = 0; busy_n = 0;
        while (!done_o && edges < 40) begin
            if (busy_o) busy_n++;
            step();
            edges++;
        end
        if (done_o && busy_o) busy_n++;
        rs = sum_o; rc = cout_o;
    endtask

    task automatic test_reset();
        a_i = 8'hFF; b_i = 8'hFF; cin_i = 1'b1; start_i = 1'b0; rst_i = 1'b1;
        step(); step();
        rst_i = 1'b0;
        total_cnt++;
        if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_o);
        else pass_cnt++;
        total_cnt++;
        if (done_o !== 1'b0) $display("FAIL reset_done: got %b expected 0", done_o);
        else pass_cnt++;
        total_cnt++;
        if (sum_o !== 8'h00) $display("FAIL reset_sum: got %h expected 00", sum_o);
        else pass_cnt++;
        total_cnt++;
        if (cout_o !== 1'b0) $display("FAIL reset_cout: got %b expected 0", cout_o);
        else pass_cnt++;
        total_cnt++;
        if ({fa_a_o, fa_b_o, fa_cin_o} !== 3'b000)
            $display("FAIL reset_fa: got %b expected 000", {fa_a_o, fa_b_o, fa_cin_o});
        else pass_cnt++;
    endtask

    task automatic test_basic_add();
        logic [WIDTH-1:0] rs; logic rc; int edges, busy_n;
        do_add(8'h5A, 8'h33, 1'b0, rs, rc, edges, busy_n);
        total_cnt++;
        if (edges !== 8) $display("FAIL basic_latency: got %0d edges expected 8", edges);
        else pass_cnt++;
        total_cnt++;
        if (rs !== 8'h8D) $display("FAIL basic_sum: got %h expected 8d", rs);
        else pass_cnt++;
        total_cnt++;
        if (rc !== 1'b0) $display("FAIL basic_cout: got %b expected 0", rc);
        else pass_cnt++;
        total_cnt++;
        if (busy_n !== 9) $display("FAIL basic_busy_cycles: got %0d expected 9", busy_n);
        else pass_cnt++;
        total_cnt++;
        if ({fa_a_o, fa_b_o, fa_cin_o} !== 3'b000)
            $display("FAIL done_fa: got %b expected 000", {fa_a_o, fa_b_o, fa_cin_o});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({done_o, busy_o} !== 2'b00)
            $display("FAIL done_pulse_width: got done/busy %b expected 00", {done_o, busy_o});
        else pass_cnt++;
        total_cnt++;
        if (sum_o !== 8'h8D) $display("FAIL idle_sum_hold: got %h expected 8d", sum_o);
        else pass_cnt++;
    endtask

    task automatic test_carry_ripple();
        logic [WIDTH-1:0] rs; logic rc; int edges, busy_n;
        do_add(8'hFF, 8'h01, 1'b0, rs, rc, edges, busy_n);
        total_cnt++;
        if ({rc, rs} !== 9'h100) $display("FAIL ripple_ff_01: got %h expected 100", {rc, rs});
        else pass_cnt++;
        step();
        do_add(8'h00, 8'h00, 1'b1, rs, rc, edges, busy_n);
        total_cnt++;
        if ({rc, rs} !== 9'h001) $display("FAIL ripple_cin_only: got %h expected 001", {rc, rs});
        else pass_cnt++;
        step();
        do_add(8'hFF, 8'hFF, 1'b1, rs, rc, edges, busy_n);
        total_cnt++;
        if ({rc, rs} !== 9'h1FF) $display("FAIL ripple_all_ones: got %h expected 1ff", {rc, rs});
        else pass_cnt++;
        step();
    endtask

    task automatic test_start_while_busy();
        logic [WIDTH-1:0] rs; logic rc; int t, edges, busy_n;
        a_i = 8'h5A; b_i = 8'h33; cin_i = 1'b0; start_i = 1'b1;
        step();
        start_i = 1'b0;
        t = 0;
        step(); step(); t = 2;
        a_i = 8'h01; b_i = 8'h01; start_i = 1'b1;
        step(); t++;
        start_i = 1'b0;
        while (!done_o && t < 40) begin
            step(); t++;
        end
        total_cnt++;
        if (t !== 8) $display("FAIL busy_start_latency: got %0d edges expected 8", t);
        else pass_cnt++;
        total_cnt++;
        if ({cout_o, sum_o} !== 9'h08D)
            $display("FAIL busy_start_result: got %h expected 08d", {cout_o, sum_o});
        else pass_cnt++;
        step();
        do_add(8'h01, 8'h01, 1'b0, rs, rc, edges, busy_n);
        total_cnt++;
        if ({rc, rs} !== 9'h002) $display("FAIL after_idle_add: got %h expected 002", {rc, rs});
        else pass_cnt++;
        step();
    endtask

    task automatic test_reset_mid_op();
        logic [WIDTH-1:0] rs; logic rc; int edges, busy_n;
        // Leave cout=1 so the reset has something to clear.
        do_add(8'hFF, 8'h01, 1'b0, rs, rc, edges, busy_n);
        step();
        a_i = 8'h5A; b_i = 8'h33; cin_i = 1'b0; start_i = 1'b1;
        step();
        start_i = 1'b0;
        total_cnt++;
        if ({fa_a_o, fa_b_o, fa_cin_o} !== 3'b010)
            $display("FAIL run_fa_bit0: got %b expected 010", {fa_a_o, fa_b_o, fa_cin_o});
        else pass_cnt++;
        step(); step(); step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        total_cnt++;
        if ({busy_o, done_o} !== 2'b00)
            $display("FAIL midrst_busy_done: got %b expected 00", {busy_o, done_o});
        else pass_cnt++;
        total_cnt++;
        if ({cout_o, sum_o} !== 9'h000)
            $display("FAIL midrst_result: got %h expected 000", {cout_o, sum_o});
        else pass_cnt++;
        total_cnt++;
        if ({fa_a_o, fa_b_o, fa_cin_o} !== 3'b000)
            $display("FAIL midrst_fa: got %b expected 000", {fa_a_o, fa_b_o, fa_cin_o});
        else pass_cnt++;
        do_add(8'h12, 8'h34, 1'b1, rs, rc, edges, busy_n);
        total_cnt++;
        if ({rc, rs} !== 9'h047 || edges !== 8)
            $display("FAIL midrst_recover: got %h after %0d edges expected 047 after 8", {rc, rs}, edges);
        else pass_cnt++;
        step();
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        logic [WIDTH-1:0] s1, s2, s_gap;
        logic c1, c2, busy_gap;
        d1 = -1; d2 = -1; s1 = '0; s2 = '0; c1 = 1'b0; c2 = 1'b0;
        s_gap = '0; busy_gap = 1'b1;
        a_i = 8'h0F; b_i = 8'h01; cin_i = 1'b0; start_i = 1'b1;
        step();
        for (int t = 0; t < 30; t++) begin
            if (t == 1) begin a_i = 8'h80; b_i = 8'h80; end
            if (t == 11) start_i = 1'b0;
            if (done_o) begin
                if (d1 < 0) begin d1 = t; s1 = sum_o; c1 = cout_o; end
                else if (d2 < 0) begin d2 = t; s2 = sum_o; c2 = cout_o; end
            end
            if (d1 >= 0 && t == d1 + 1) begin s_gap = sum_o; busy_gap = busy_o; end
            step();
        end
        start_i = 1'b0;
        total_cnt++;
        if (d1 !== 8) $display("FAIL b2b_first_done: got cycle %0d expected 8", d1);
        else pass_cnt++;
        total_cnt++;
        if (d2 - d1 !== WIDTH + 2) $display("FAIL b2b_spacing: got %0d expected %0d", d2 - d1, WIDTH + 2);
        else pass_cnt++;
        total_cnt++;
        if ({c1, s1} !== 9'h010) $display("FAIL b2b_first_result: got %h expected 010", {c1, s1});
        else pass_cnt++;
        total_cnt++;
        if ({c2, s2} !== 9'h100) $display("FAIL b2b_second_result: got %h expected 100", {c2, s2});
        else pass_cnt++;
        total_cnt++;
        if ({busy_gap, s_gap} !== 9'h010)
            $display("FAIL b2b_gap_hold: got busy/sum %h expected 010", {busy_gap, s_gap});
        else pass_cnt++;
        total_cnt++;
        if (busy_o !== 1'b0) $display("FAIL b2b_no_third: got busy %b expected 0", busy_o);
        else pass_cnt++;
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        logic [WIDTH-1:0] rs; logic rc; int edges, busy_n;
        sub_i = 1'b1;
        do_add(8'h10, 8'h01, 1'b0, rs, rc, edges, busy_n);
        total_cnt++;
        if ({rc, rs} !== 9'h10F) $display("FAIL sub_no_borrow: got %h expected 10f", {rc, rs});
        else pass_cnt++;
        step();
        do_add(8'h01, 8'h02, 1'b0, rs, rc, edges, busy_n);
        total_cnt++;
        if ({rc, rs} !== 9'h0FF) $display("FAIL sub_borrow: got %h expected 0ff", {rc, rs});
        else pass_cnt++;
        step();
        sub_i = 1'b0;
        do_add(8'h10, 8'h01, 1'b1, rs, rc, edges, busy_n);
        total_cnt++;
        if ({rc, rs} !== 9'h012) $display("FAIL sub_off_add: got %h expected 012", {rc, rs});
        else pass_cnt++;
        step();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub_i = 1'b0;
`endif
        test_reset();
        test_basic_add();
        test_carry_ripple();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
